// File: rtl/gc_dram_pkg.sv
// Shared types and geometry for the gain-cell DRAM macro and its refresh controller.
package gc_dram_pkg;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 64;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int DRT_CYCLES   = 4096;
  localparam int REF_INTERVAL = 3;
  localparam int AGE_W        = $clog2(DRT_CYCLES + 1);
  localparam int TICK_W       = $clog2(REF_INTERVAL + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [AGE_W-1:0]  age_t;
  typedef logic [TICK_W-1:0] tick_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    REFRESH
  } ref_state_t;

endpackage

// File: rtl/gc_dram_array.sv
// Behavioural gain-cell storage: per-row valid bits and age counters, with rows
// expiring after DRT_CYCLES unless rewritten by the user or the refresh port.
module gc_array
  import gc_dram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W-1:0] ref_addr,
  output logic [DATA_W-1:0] ref_data,
  output logic              ref_valid,
  input  logic              ref_wr_en,
  input  logic [DATA_W-1:0] ref_wr_data
);

  data_t            mem [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  age_t             age_q [DEPTH];
  age_t             age_d [DEPTH];
  logic             ref_hit;

  // A user write to the row being refreshed supersedes the refresh rewrite.
  assign ref_hit = ref_wr_en && !(wr_en && (wr_addr == ref_addr));

  assign rd_data   = mem[rd_addr];
  assign rd_valid  = valid_q[rd_addr];
  assign ref_data  = mem[ref_addr];
  assign ref_valid = valid_q[ref_addr];

  always_comb begin
    // NOTE: every signal gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (valid_q[i]) begin
        age_d[i] = age_q[i] + age_t'(1);
        if (age_q[i] == age_t'(DRT_CYCLES - 1)) valid_d[i] = 1'b0;
      end
    end
    if (ref_hit) begin
      valid_d[ref_addr] = 1'b1;
      age_d[ref_addr]   = '0;
    end
    if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
      age_d[wr_addr]   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // NOTE: the storage itself is never reset; cleared valid bits make stale content unreadable.
  always_ff @(posedge clk) begin
    if (ref_hit) mem[ref_addr] <= ref_wr_data;
    if (wr_en)   mem[wr_addr]  <= wr_data;
  end

endmodule

// File: rtl/gc_dram_top.sv
// GC-DRAM macro top: storage array plus a pointer-sweeping refresh engine that
// restores only valid rows, and the registered read port with hi-Z/X signalling.
module gc_dram_top
  import gc_dram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              disable_ref,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] in,
  output logic              busy,
  output logic [DATA_W-1:0] rd
);

  ref_state_t state_q, state_d;
  addr_t      ptr_q, ptr_d;
  addr_t      ref_row_q, ref_row_d;
  tick_t      tick_q, tick_d;
  data_t      rd_q, rd_d;
  logic       rd_en_q, rd_en_d;

  data_t arr_rd_data, ref_data;
  logic  arr_rd_valid, ref_valid, ref_wr_en;
  addr_t ref_addr;

  // In IDLE the refresh-read path probes the pointer row; otherwise it holds the pending row.
  assign ref_addr = (state_q == IDLE) ? ptr_q : ref_row_q;

  gc_array u_array (
    .clk         (clk),
    .rst_n       (rst),
    .wr_en       (we),
    .wr_addr     (waddr),
    .wr_data     (in),
    .rd_addr     (raddr),
    .rd_data     (arr_rd_data),
    .rd_valid    (arr_rd_valid),
    .ref_addr    (ref_addr),
    .ref_data    (ref_data),
    .ref_valid   (ref_valid),
    .ref_wr_en   (ref_wr_en),
    .ref_wr_data (ref_data)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ref_row_d = ref_row_q;
    tick_d    = tick_q;
    ref_wr_en = 1'b0;
    if (disable_ref) begin
      state_d = IDLE;
    end else begin
      if (tick_q != tick_t'(REF_INTERVAL - 1)) tick_d = tick_q + tick_t'(1);
      unique case (state_q)
        IDLE: begin
          // The pointer only advances while idle, so a stalled refresh never skips a row.
          if (tick_q == tick_t'(REF_INTERVAL - 1)) begin
            tick_d = '0;
            ptr_d  = ptr_q + addr_t'(1);
            if (ref_valid) begin
              state_d   = PEND;
              ref_row_d = ptr_q;
            end
          end
        end
        PEND: begin
          if (we && (waddr == ref_row_q)) state_d = IDLE;
          else if (!we)                   state_d = REFRESH;
        end
        REFRESH: begin
          ref_wr_en = ref_valid;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE) && !disable_ref;

  always_comb begin
    rd_en_d = rd_en_q | re;
    rd_d    = 'x;
    if (re && !(we && (waddr == raddr)) && arr_rd_valid) rd_d = arr_rd_data;
  end

  assign rd = rd_en_q ? rd_q : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      ref_row_q <= '0;
      tick_q    <= '0;
      rd_q      <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ref_row_q <= ref_row_d;
      tick_q    <= tick_d;
      rd_q      <= rd_d;
      rd_en_q   <= rd_en_d;
    end
  end

endmodule

// File: tb/tb_gc_dram_top.sv
// Self-checking bench for gc_dram_top: vector table, scoreboard queue and
// hand-written sequences for refresh retention, collisions, disable and reset.
module tb_gc_dram_top;
  import gc_dram_pkg::*;

  typedef enum logic [1:0] {EXP_NONE, EXP_DATA, EXP_BAD} kind_t;
  typedef struct {
    kind_t kind;
    data_t val;
  } exp_t;
  typedef struct {
    logic  we;
    addr_t waddr;
    data_t wdata;
    logic  re;
    addr_t raddr;
    kind_t kind;
    data_t val;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  we = 1'b0, re = 1'b0, disable_ref = 1'b0;
  addr_t waddr = '0, raddr = '0;
  data_t wdata = '0;
  wire   busy;
  wire [DATA_W-1:0] rd;

  int total = 0;
  int bad   = 0;
  exp_t  sb_q[$];
  string sb_name_q[$];
  data_t model [int];

  gc_dram_top dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .re          (re),
    .disable_ref (disable_ref),
    .waddr       (waddr),
    .raddr       (raddr),
    .in          (wdata),
    .busy        (busy),
    .rd          (rd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input bit ok, input data_t act, input data_t req,
                       input bit negated);
    total++;
    if (!ok) begin
      bad++;
      if (negated) $display("FAIL %s: got %h, required invalid (not %h)", name, act, req);
      else         $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic compare_rd(input string name, input kind_t k, input data_t v);
    data_t act;
    act = rd;
    if (k == EXP_DATA) check(name, act === v, act, v, 1'b0);
    else if (k == EXP_BAD) check(name, $isunknown(act) || (act != v), act, v, 1'b1);
  endtask

  // Drive one cycle, queue the expected rd for the edge, then pop and compare after it.
  task automatic drive_cycle(input logic w, input addr_t wa, input data_t wd, input logic r,
                             input addr_t ra, input kind_t k, input data_t v, input string nm);
    exp_t e;
    string n;
    we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
    sb_q.push_back('{k, v});
    sb_name_q.push_back(nm);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n = sb_name_q.pop_front();
    compare_rd(n, e.kind, e.val);
    if (w) model[int'(wa)] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, '0, EXP_NONE, '0, "idle");
  endtask

  localparam data_t D0 = 64'h0123_4567_89AB_CDEF;
  localparam data_t D1 = 64'h5555_AAAA_1234_0F0F;
  localparam data_t D2 = 64'hCAFE_F00D_0BAD_BEEF;
  localparam data_t D3 = 64'h0F1E_2D3C_4B5A_6978;
  localparam data_t D4 = 64'h1111_2222_3333_4444;
  localparam data_t D5 = 64'h7654_3210_FEDC_BA98;
  localparam data_t DB = 64'hDEAD_BEEF_0000_0001;

  initial begin
    vec_t vt[7];
    int   errs, since, max_gap, pulses, waited;
    bit   prev_busy, busy_seen;
    addr_t a;
    data_t d, forb;

    vt[0] = '{1'b0, 10'd0, '0, 1'b0, 10'd0, EXP_BAD,  D0};
    vt[1] = '{1'b1, 10'd5, D0, 1'b0, 10'd0, EXP_BAD,  D0};
    vt[2] = '{1'b0, 10'd0, '0, 1'b1, 10'd5, EXP_DATA, D0};
    vt[3] = '{1'b0, 10'd0, '0, 1'b0, 10'd5, EXP_BAD,  D0};
    vt[4] = '{1'b1, 10'd6, D1, 1'b1, 10'd5, EXP_DATA, D0};
    vt[5] = '{1'b0, 10'd0, '0, 1'b1, 10'd6, EXP_DATA, D1};
    vt[6] = '{1'b0, 10'd0, '0, 1'b1, 10'd7, EXP_BAD,  D1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy === 1'b0, data_t'(busy), '0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++)
      drive_cycle(vt[i].we, vt[i].waddr, vt[i].wdata, vt[i].re, vt[i].raddr,
                  vt[i].kind, vt[i].val, $sformatf("vec%0d", i));

    for (int i = 0; i < 32; i++) begin
      a = addr_t'($urandom_range(8, 1000));
      d = {$urandom, $urandom} | 64'h1;
      drive_cycle(1'b1, a, d, 1'b0, '0, EXP_NONE, '0, "rand_wr");
      drive_cycle(1'b0, '0, '0, 1'b1, a, EXP_DATA, d, $sformatf("rand_rd%0d", i));
      drive_cycle(1'b0, '0, '0, 1'b0, a, EXP_BAD, d, $sformatf("rand_idle%0d", i));
    end

    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 10'h100, DB, 1'b1, 10'h100, EXP_BAD, DB, $sformatf("collide%0d", i));
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h100, EXP_DATA, DB, "after_collide");

    // Retention under refresh: the row must survive well past DRT_CYCLES.
    drive_cycle(1'b1, 10'h2A5, D2, 1'b0, '0, EXP_NONE, '0, "hold_wr");
    errs = 0; since = 0; max_gap = 0; pulses = 0; prev_busy = busy;
    we = 1'b0; re = 1'b1; raddr = 10'h2A5;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (rd !== D2) errs++;
      if (busy && !prev_busy) begin
        if (since > max_gap) max_gap = since;
        since = 0;
        pulses++;
      end else begin
        since++;
      end
      prev_busy = busy;
    end
    if (since > max_gap) max_gap = since;
    check("hold_data_errs", errs == 0, data_t'(errs), '0, 1'b0);
    check("busy_gap_le_3072", max_gap <= 3072, data_t'(max_gap), 64'd3072, 1'b0);
    check("busy_pulses", pulses >= 1, data_t'(pulses), 64'd1, 1'b0);

    // Refresh disabled: rows decay and busy never rises.
    disable_ref = 1'b1;
    #1;
    check("disable_busy", busy === 1'b0, data_t'(busy), '0, 1'b0);
    busy_seen = 1'b0;
    drive_cycle(1'b1, 10'h3FF, D3, 1'b0, '0, EXP_NONE, '0, "dis_wr");
    for (int i = 0; i < 99; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, '0, EXP_NONE, '0, "dis_wait");
      busy_seen |= busy;
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h3FF, EXP_DATA, D3, "dis_early_rd");
    for (int i = 0; i < 5900; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, '0, EXP_NONE, '0, "dis_wait");
      busy_seen |= busy;
    end
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h3FF, EXP_BAD, D3, "dis_decayed_3ff");
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h2A5, EXP_BAD, D2, "dis_decayed_2a5");
    check("dis_busy_never", busy_seen == 1'b0, data_t'(busy_seen), '0, 1'b0);

    // Re-enable: the engine must find the one valid row within a sweep.
    disable_ref = 1'b0;
    drive_cycle(1'b1, 10'h010, D4, 1'b0, '0, EXP_NONE, '0, "resume_wr");
    waited = 0;
    while (!busy && waited < 3200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("resume_busy", busy === 1'b1, data_t'(busy), 64'd1, 1'b0);
    idle(3);
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h010, EXP_DATA, D4, "resume_rd");

    // Asynchronous reset between edges.
    drive_cycle(1'b1, 10'h055, D5, 1'b0, '0, EXP_NONE, '0, "rst_wr");
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h055, EXP_DATA, D5, "rst_pre_rd");
    re = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", busy === 1'b0, data_t'(busy), '0, 1'b0);
    compare_rd("async_rst_rd_z", EXP_BAD, D5);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    drive_cycle(1'b0, '0, '0, 1'b0, '0, EXP_BAD, D5, "post_rst_idle");
    drive_cycle(1'b0, '0, '0, 1'b1, 10'h055, EXP_BAD, D5, "post_rst_rd");

    a = addr_t'($urandom_range(0, DEPTH - 1));
    forb = model.exists(int'(a)) ? (model[int'(a)] | 64'h1) : D0;
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b0, '0, '0, 1'b1, a, EXP_BAD, forb, $sformatf("unwritten_rd%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
